// File: rtl/vram_arbiter_if.sv
// Bus bundle for the VRAM arbiter: CPU write port, VGA read port, RAM port and
// the write-buffer fill level. The arbiter binds to the slave modport and its
// environment (CPU, VGA, RAM) binds to the master modport.
interface vram_arbiter_if #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              cpu_wr_valid;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              cpu_wr_ready;

    logic              vga_rd_req;
    logic [ADDR_W-1:0] vga_rd_addr;
    logic              vga_rd_gnt;
    logic              vga_rd_valid;
    logic [DATA_W-1:0] vga_rd_data;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [LVL_W-1:0]  fifo_level;

    modport slave (
        input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
        input  vga_rd_req, vga_rd_addr,
        input  ram_rdata,
        output cpu_wr_ready,
        output vga_rd_gnt, vga_rd_valid, vga_rd_data,
        output ram_en, ram_we, ram_addr, ram_wdata,
        output fifo_level
    );

    modport master (
        output cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
        output vga_rd_req, vga_rd_addr,
        output ram_rdata,
        input  cpu_wr_ready,
        input  vga_rd_gnt, vga_rd_valid, vga_rd_data,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        input  fifo_level
    );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one single-port synchronous RAM between a VGA reader
// (priority) and a buffered CPU writer. CPU writes land in a small FIFO and
// drain in acceptance order whenever VGA is not using the RAM.
//
// Optional feature: define VRAM_ARB_STARVE_GUARD_EN to build the starvation
// guard. After STARVE_LIMIT consecutive VGA grants with writes pending, the
// next cycle is given to the oldest buffered write. Without the macro VGA
// has absolute priority and the guard counter does not exist.
module vram_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    vram_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("vram_arbiter: FIFO_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [LVL_W-1:0]  level_next;
    logic              ready_q;
    logic              rd_valid_q;
    logic              empty;
    logic              push;
    logic              pop;
    logic              gnt;
    logic              forced;

    assign empty = (level == '0);
    // Ready is registered not-full, so a push is never taken at full even if
    // the head drains in the same cycle.
    assign push  = bus.cpu_wr_valid && ready_q;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign forced = !empty && (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Count VGA grants that starve a pending write; any write or an empty buffer clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (pop || empty) begin
            starve_cnt <= '0;
        end else if (gnt && starve_cnt != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    assign forced = 1'b0;
`endif

    // Arbitration: VGA wins unless the guard forces a write; grants are gated
    // by reset so the RAM stays idle while reset is held low.
    always_comb begin
        gnt = 1'b0;
        pop = 1'b0;
        gnt = reset && bus.vga_rd_req && !forced;
        pop = reset && !gnt && !empty;
    end

    // Next fill level from this cycle's push/pop pair.
    always_comb begin
        level_next = level;
        unique case ({push, pop})
            2'b10:   level_next = level + LVL_W'(1);
            2'b01:   level_next = level - LVL_W'(1);
            default: level_next = level;
        endcase
    end

    // Buffer pointers, level, registered ready and read-valid pipeline stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            ready_q    <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level      <= level_next;
            ready_q    <= (level_next != LVL_W'(FIFO_DEPTH));
            rd_valid_q <= gnt;
        end
    end

    // Buffer storage needs no reset: entries are only read below the level.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.cpu_wr_addr;
            fifo_data[wr_ptr] <= bus.cpu_wr_data;
        end
    end

    assign bus.cpu_wr_ready = ready_q;
    assign bus.vga_rd_gnt   = gnt;
    assign bus.vga_rd_valid = rd_valid_q;
    // RAM has one cycle of read latency, so its output lines up with rd_valid_q.
    assign bus.vga_rd_data  = bus.ram_rdata;
    assign bus.ram_en       = gnt || pop;
    assign bus.ram_we       = pop;
    assign bus.ram_addr     = pop ? fifo_addr[rd_ptr] : bus.vga_rd_addr;
    assign bus.ram_wdata    = fifo_data[rd_ptr];
    assign bus.fifo_level   = level;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a RAM model and write/read scoreboards.
module tb_vram_arbiter;
    localparam int AW = 11;
    localparam int DW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) bus();

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    wr_t           wq[$];
    logic [DW-1:0] rq[$];
    int            passed = 0;
    int            total  = 0;
    logic          prev_gnt = 1'b0;

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(i * 7 + 32'h3000);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Single-port synchronous RAM, one cycle read latency.
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= ram[bus.ram_addr];
        end
    end

    // Cycle monitor: scoreboards for writes and reads plus per-cycle protocol checks.
    always @(negedge clk) begin
        if (!reset) begin
            prev_gnt = 1'b0;
        end else begin
            check("rd_valid_latency", bus.vga_rd_valid, prev_gnt);
            if (bus.vga_rd_valid) begin
                check("rd_pending", rq.size() > 0, 1);
                if (rq.size() > 0) check("rd_data", bus.vga_rd_data, rq.pop_front());
            end
            check("ram_en", bus.ram_en, bus.vga_rd_gnt | bus.ram_we);
`ifndef VRAM_ARB_STARVE_GUARD_EN
            check("vga_priority", bus.vga_rd_gnt, bus.vga_rd_req);
`endif
            if (bus.vga_rd_gnt) begin
                check("gnt_req", bus.vga_rd_req, 1);
                check("gnt_we", bus.ram_we, 0);
                check("gnt_addr", bus.ram_addr, bus.vga_rd_addr);
                rq.push_back(ref_mem[bus.vga_rd_addr]);
            end
            if (bus.ram_we) begin
                check("wr_pending", wq.size() > 0, 1);
                if (wq.size() > 0) begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_addr", bus.ram_addr, e.addr);
                    check("wr_data", bus.ram_wdata, e.data);
                    ref_mem[e.addr] = e.data;
                end
            end
            if (bus.cpu_wr_valid && bus.cpu_wr_ready)
                wq.push_back('{addr: bus.cpu_wr_addr, data: bus.cpu_wr_data});
            prev_gnt = bus.vga_rd_gnt;
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        reset            = 1'b0;
        bus.cpu_wr_valid = 1'b0;
        bus.cpu_wr_addr  = '0;
        bus.cpu_wr_data  = '0;
        bus.vga_rd_req   = 1'b1;
        bus.vga_rd_addr  = AW'(12'h005);

        // Reset state, with a VGA request held to show the RAM stays idle.
        #12;
        check("rst_ready", bus.cpu_wr_ready, 1);
        check("rst_level", bus.fifo_level, 0);
        check("rst_ram_en", bus.ram_en, 0);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_rd_valid", bus.vga_rd_valid, 0);
        check("rst_gnt", bus.vga_rd_gnt, 0);
        bus.vga_rd_req = 1'b0;
        cyc();
        reset = 1'b1;

        // Single CPU write with VGA idle.
        bus.cpu_wr_valid = 1'b1;
        bus.cpu_wr_addr  = AW'(12'h010);
        bus.cpu_wr_data  = 16'hBEEF;
        @(negedge clk);
        check("w1_ready", bus.cpu_wr_ready, 1);
        check("w1_idle_en", bus.ram_en, 0);
        cyc();
        bus.cpu_wr_valid = 1'b0;
        @(negedge clk);
        check("w1_we", bus.ram_we, 1);
        check("w1_addr", bus.ram_addr, 12'h010);
        check("w1_data", bus.ram_wdata, 16'hBEEF);
        check("w1_level", bus.fifo_level, 1);
        cyc();
        @(negedge clk);
        check("w1_level_after", bus.fifo_level, 0);
        check("w1_en_after", bus.ram_en, 0);

        // VGA read of the freshly written word.
        cyc();
        bus.vga_rd_req  = 1'b1;
        bus.vga_rd_addr = AW'(12'h010);
        @(negedge clk);
        check("r1_gnt", bus.vga_rd_gnt, 1);
        check("r1_we", bus.ram_we, 0);
        check("r1_addr", bus.ram_addr, 12'h010);
        cyc();
        bus.vga_rd_req = 1'b0;
        @(negedge clk);
        check("r1_valid", bus.vga_rd_valid, 1);
        check("r1_data", bus.vga_rd_data, 16'hBEEF);
        check("r1_gnt_off", bus.vga_rd_gnt, 0);

        // Five back-to-back writes while VGA holds the RAM: buffer fills at four.
        cyc();
        bus.vga_rd_req  = 1'b1;
        bus.vga_rd_addr = AW'(12'h020);
        for (int i = 0; i < 6; i++) begin
            int k;
            k = (i < 5) ? i : 4;
            bus.cpu_wr_valid = 1'b1;
            bus.cpu_wr_addr  = AW'(12'h100 + k);
            bus.cpu_wr_data  = DW'(16'h1000 + k);
            @(negedge clk);
            check("fill_level", bus.fifo_level, (i < 4) ? i : 4);
            check("fill_ready", bus.cpu_wr_ready, (i < 4) ? 1 : 0);
            check("fill_no_write", bus.ram_we, 0);
            cyc();
        end
        bus.cpu_wr_valid = 1'b0;
        bus.vga_rd_req   = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("drain_we", bus.ram_we, 1);
            check("drain_addr", bus.ram_addr, 12'h100 + j);
            check("drain_level", bus.fifo_level, 4 - j);
            cyc();
        end
        @(negedge clk);
        check("drain_done_level", bus.fifo_level, 0);
        check("drain_done_ready", bus.cpu_wr_ready, 1);
        check("drain_done_en", bus.ram_en, 0);

        // One buffered write against a continuous VGA request.
        cyc();
        bus.vga_rd_req   = 1'b1;
        bus.vga_rd_addr  = AW'(12'h030);
        bus.cpu_wr_valid = 1'b1;
        bus.cpu_wr_addr  = AW'(12'h055);
        bus.cpu_wr_data  = 16'h5555;
        @(negedge clk);
        check("starve_c0_gnt", bus.vga_rd_gnt, 1);
        cyc();
        bus.cpu_wr_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
`ifdef VRAM_ARB_STARVE_GUARD_EN
            check("starve_gnt", bus.vga_rd_gnt, (i == 9) ? 0 : 1);
            check("starve_we", bus.ram_we, (i == 9) ? 1 : 0);
            check("starve_level", bus.fifo_level, (i <= 9) ? 1 : 0);
`else
            check("starve_gnt", bus.vga_rd_gnt, 1);
            check("starve_we", bus.ram_we, 0);
            check("starve_level", bus.fifo_level, 1);
`endif
            cyc();
        end
        bus.vga_rd_req = 1'b0;
        @(negedge clk);
`ifdef VRAM_ARB_STARVE_GUARD_EN
        check("starve_tail_en", bus.ram_en, 0);
`else
        check("starve_tail_we", bus.ram_we, 1);
        check("starve_tail_addr", bus.ram_addr, 12'h055);
`endif
        cyc();
        @(negedge clk);
        check("starve_tail_level", bus.fifo_level, 0);

        // Reset mid-operation with three writes buffered and reads in flight.
        cyc();
        bus.vga_rd_req  = 1'b1;
        bus.vga_rd_addr = AW'(12'h040);
        for (int i = 0; i < 3; i++) begin
            bus.cpu_wr_valid = 1'b1;
            bus.cpu_wr_addr  = AW'(12'h200 + i);
            bus.cpu_wr_data  = DW'(16'hA000 + i);
            cyc();
        end
        bus.cpu_wr_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_level", bus.fifo_level, 3);
        check("pre_rst_valid", bus.vga_rd_valid, 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        wq.delete();
        rq.delete();
        #1;
        check("async_level", bus.fifo_level, 0);
        check("async_valid", bus.vga_rd_valid, 0);
        check("async_en", bus.ram_en, 0);
        check("async_ready", bus.cpu_wr_ready, 1);
        cyc();
        reset          = 1'b1;
        bus.vga_rd_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_en", bus.ram_en, 0);
            check("post_rst_level", bus.fifo_level, 0);
            cyc();
        end

        // Discarded entries never reached RAM.
        bus.vga_rd_req  = 1'b1;
        bus.vga_rd_addr = AW'(12'h200);
        @(negedge clk);
        check("resume_gnt", bus.vga_rd_gnt, 1);
        cyc();
        bus.vga_rd_req = 1'b0;
        @(negedge clk);
        check("discard_valid", bus.vga_rd_valid, 1);
        check("discard_data", bus.vga_rd_data, 16'h3E00);
        cyc();
        cyc();

        check("wq_drained", wq.size(), 0);
        check("rq_drained", rq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, VRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, VRAM word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, CPU write-buffer entries (power of two).
REQ-004 SHALL have parameter STARVE_LIMIT, default 8, consecutive VGA grants before a forced CPU write.
REQ-005 SHALL have port clk  input  1  single clock, rising-edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port cpu_wr_valid  input  1  CPU write request.
REQ-008 SHALL have port cpu_wr_addr  input  ADDR_W  CPU write address.
REQ-009 SHALL have port cpu_wr_data  input  DATA_W  CPU write data.
REQ-010 SHALL have port cpu_wr_ready  output  1  write accepted this cycle when high with cpu_wr_valid.
REQ-011 SHALL have port vga_rd_req  input  1  VGA read request, held until granted.
REQ-012 SHALL have port vga_rd_addr  input  ADDR_W  VGA read address.
REQ-013 SHALL have port vga_rd_gnt  output  1  VGA read issued to RAM this cycle.
REQ-014 SHALL have port vga_rd_valid  output  1  vga_rd_data valid.
REQ-015 SHALL have port vga_rd_data  output  DATA_W  VGA read data.
REQ-016 SHALL have ports ram_en, ram_we (output, 1), ram_addr (output, ADDR_W), ram_wdata (output, DATA_W), ram_rdata (input, DATA_W): single-port synchronous RAM, 1-cycle read latency.
REQ-017 SHALL have port fifo_level  output  clog2(FIFO_DEPTH)+1  buffered CPU writes.

Function
REQ-018 SHALL issue at most one RAM access per cycle; ram_en high only on a read or write grant.
REQ-019 SHALL accept a CPU write (push) when cpu_wr_valid and cpu_wr_ready; cpu_wr_ready = registered not-full, so no push occurs at full even if a pop happens the same cycle.
REQ-020 SHALL grant VGA (vga_rd_gnt=1, ram_we=0, ram_addr=vga_rd_addr) whenever vga_rd_req is high, unless a forced write applies (REQ-023).
REQ-021 SHALL, when VGA is not granted and FIFO non-empty, pop the head and write it (ram_we=1) in the same cycle.
REQ-022 SHALL assert vga_rd_valid exactly one cycle after each vga_rd_gnt, with vga_rd_data = ram_rdata, and deassert it otherwise.
REQ-023 SHALL count consecutive VGA grants while FIFO non-empty; on reaching STARVE_LIMIT the next cycle is a forced write (vga_rd_gnt=0 even if vga_rd_req=1); counter clears on any write or when FIFO empty.
REQ-024 SHALL NOT forward buffered data to VGA reads; a read of an address pending in the FIFO returns the RAM's current contents.
REQ-025 SHALL support simultaneous push and pop when neither full nor empty; fifo_level unchanged.
REQ-026 SHALL write FIFO entries to RAM in acceptance order; pointers wrap modulo FIFO_DEPTH.
REQ-027 SHALL drive ram_en=0 when no VGA request and FIFO empty.

Reset
REQ-028 SHALL, while reset is low, asynchronously clear FIFO pointers, fifo_level=0, starvation counter=0, vga_rd_valid=0, ram_en=0, ram_we=0, cpu_wr_ready=1 (registered not-full).
REQ-029 SHALL discard all buffered writes on reset, including a write in flight; an outstanding read produces no vga_rd_valid after reset.
REQ-030 SHALL resume arbitration on the first rising clk edge after reset deasserts.

Configuration
REQ-031 SHALL implement REQ-023 only when macro VRAM_ARB_STARVE_GUARD_EN is defined; without it VGA has absolute priority, CPU writes occur only in cycles without vga_rd_req, and the counter is not built.

Verification
REQ-032 SHALL verify: after reset, single CPU write (addr 0x010, data 0xBEEF) with VGA idle -> ram_we=1, addr 0x010, data 0xBEEF one cycle after push; fifo_level returns 0.
REQ-033 SHALL verify: VGA read addr 0x010 after REQ-032 -> vga_rd_gnt same cycle, vga_rd_valid next cycle with data 0xBEEF.
REQ-034 SHALL verify: 5 CPU writes back-to-back with vga_rd_req held high, guard off -> 4 accepted, cpu_wr_ready=0, fifo_level=4, no RAM writes until vga_rd_req drops, then 4 writes in order.
REQ-035 SHALL verify: guard on, vga_rd_req held high, one buffered write -> 8 VGA grants, then one cycle vga_rd_gnt=0 with the write, then VGA grants resume.
REQ-036 SHALL verify: reset pulsed low mid-operation with fifo_level=3 -> fifo_level=0, vga_rd_valid=0, ram_en=0 immediately (asynchronous), no further writes of discarded entries.
